// File: rtl/decode_issue_stage.sv
// RV32I decode/issue stage: OP/OP-IMM/LUI/AUIPC decode, 32x32 register file, one-entry output register.
// Optional define WB_BYPASS_EN: writeback data forwarded to operands read in the same cycle.
module decode_issue_stage #(
  parameter int unsigned XLEN     = 32,
  parameter logic [31:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_sel,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [4:0]      out_rd,
  output logic            out_we,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t state, state_nxt;
  logic   accept;

  logic [XLEN-1:0] regs [32];
  logic [XLEN-1:0] rs1_val, rs2_val;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rs1, rs2, rd;

  logic            dec_legal;
  logic [3:0]      dec_sel;
  logic [XLEN-1:0] dec_a, dec_b;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign funct3 = in_instr[14:12];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign funct7 = in_instr[31:25];

  assign out_valid = (state == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_en && wb_rd != '0) begin
      regs[wb_rd] <= wb_data;
    end
  end

  always_comb begin
    rs1_val = (rs1 == '0) ? '0 : regs[rs1];
    rs2_val = (rs2 == '0) ? '0 : regs[rs2];
`ifdef WB_BYPASS_EN
    if (wb_en && rs1 != '0 && wb_rd == rs1) rs1_val = wb_data;
    if (wb_en && rs2 != '0 && wb_rd == rs2) rs2_val = wb_data;
`endif
  end

  always_comb begin
    dec_legal = 1'b0;
    dec_sel   = '0;
    dec_a     = '0;
    dec_b     = '0;
    case (opcode)
      7'b0110011: begin
        dec_a = rs1_val;
        dec_b = (funct3 == 3'b001 || funct3 == 3'b101) ?
                {{(XLEN-5){1'b0}}, rs2_val[4:0]} : rs2_val;
        if (funct7 == 7'b0000000) begin
          dec_legal = 1'b1;
          dec_sel   = {1'b0, funct3};
        end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          dec_legal = 1'b1;
          dec_sel   = {1'b1, funct3};
        end
      end
      7'b0010011: begin
        dec_a = rs1_val;
        case (funct3)
          3'b001: begin
            dec_b     = {{(XLEN-5){1'b0}}, in_instr[24:20]};
            dec_legal = (funct7 == 7'b0000000);
            dec_sel   = 4'b0001;
          end
          3'b101: begin
            dec_b = {{(XLEN-5){1'b0}}, in_instr[24:20]};
            if (funct7 == 7'b0000000) begin
              dec_legal = 1'b1;
              dec_sel   = 4'b0101;
            end else if (funct7 == 7'b0100000) begin
              dec_legal = 1'b1;
              dec_sel   = 4'b1101;
            end
          end
          default: begin
            dec_b     = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
            dec_legal = 1'b1;
            dec_sel   = {1'b0, funct3};
          end
        endcase
      end
      7'b0110111: begin
        dec_legal = 1'b1;
        dec_b     = XLEN'({in_instr[31:12], 12'b0});
      end
      7'b0010111: begin
        dec_legal = 1'b1;
        dec_a     = in_pc;
        dec_b     = XLEN'({in_instr[31:12], 12'b0});
      end
      default: dec_legal = 1'b0;
    endcase
    if (!dec_legal) begin
      dec_sel = '0;
      dec_a   = '0;
      dec_b   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = FULL;
      FULL:    if (out_ready && !accept) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // Payload only loads on accept, so a stalled FULL entry holds every field stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_sel     <= '0;
      out_a       <= '0;
      out_b       <= '0;
      out_rd      <= '0;
      out_we      <= 1'b0;
      out_illegal <= 1'b0;
      out_pc      <= XLEN'(RESET_PC);
    end else if (accept) begin
      out_sel     <= dec_sel;
      out_a       <= dec_a;
      out_b       <= dec_b;
      out_rd      <= rd;
      out_we      <= dec_legal && (rd != '0);
      out_illegal <= !dec_legal;
      out_pc      <= in_pc;
    end
  end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Self-checking bench for decode_issue_stage: directed scenarios plus randomized traffic
// against a mnemonic-level reference model of decode, register file and output handshake.
module tb_decode_issue_stage;

  localparam logic [31:0] RP = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_sel;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [4:0]  out_rd;
  logic        out_we;
  logic        out_illegal;
  logic [31:0] out_pc;

  int checks = 0;
  int errors = 0;

  decode_issue_stage #(.XLEN(32), .RESET_PC(RP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sel(out_sel), .out_a(out_a), .out_b(out_b), .out_rd(out_rd),
    .out_we(out_we), .out_illegal(out_illegal), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  logic [31:0] mregs [32];
  logic        m_valid;
  exp_t        m_out;
  logic [31:0] m_pc;

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] r2,
                                        input logic [4:0] r1, input logic [2:0] f3,
                                        input logic [4:0] d, input logic [6:0] op);
    return {f7, r2, r1, f3, d, op};
  endfunction

  function automatic logic [31:0] mread(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
`ifdef WB_BYPASS_EN
    if (wb_en && wb_rd == idx) return wb_data;
`endif
    return mregs[idx];
  endfunction

  // Reference decode by instruction class and mnemonic.
  function automatic exp_t predict(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    logic legal;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    e = '0;
    legal = 1'b0;
    if (op == 7'h33) begin
      e.a = r1;
      e.b = (f3 == 3'd1 || f3 == 3'd5) ? (r2 % 32) : r2;
      if (f7 == 7'h00) begin legal = 1'b1; e.sel = 4'(f3); end
      else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin legal = 1'b1; e.sel = 4'(f3) + 4'd8; end
    end else if (op == 7'h13) begin
      e.a = r1;
      if (f3 == 3'd1 || f3 == 3'd5) begin
        e.b = 32'(ins[24:20]);
        if (f7 == 7'h00) begin legal = 1'b1; e.sel = 4'(f3); end
        else if (f7 == 7'h20 && f3 == 3'd5) begin legal = 1'b1; e.sel = 4'd13; end
      end else begin
        e.b = 32'($signed(ins[31:20]));
        legal = 1'b1;
        e.sel = 4'(f3);
      end
    end else if (op == 7'h37) begin
      legal = 1'b1;
      e.b = ins & 32'hFFFF_F000;
    end else if (op == 7'h17) begin
      legal = 1'b1;
      e.a = pc;
      e.b = ins & 32'hFFFF_F000;
    end
    if (!legal) e = '0;
    e.rd  = ins[11:7];
    e.ill = !legal;
    e.we  = legal && (ins[11:7] != 0);
    return e;
  endfunction

  // Advances one clock and steps the reference model with the inputs presented this cycle.
  task automatic tick();
    logic acc;
    exp_t nx;
    logic [31:0] npc;
    acc = in_valid && (!m_valid || out_ready);
    nx  = predict(in_instr, in_pc, mread(in_instr[19:15]), mread(in_instr[24:20]));
    npc = in_pc;
    @(posedge clk);
    #1;
    if (rst) begin
      m_valid = 1'b0;
      m_out   = '0;
      m_pc    = RP;
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    end else begin
      if (wb_en && wb_rd != 0) mregs[wb_rd] = wb_data;
      if (acc) begin
        m_valid = 1'b1;
        m_out   = nx;
        m_pc    = npc;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic wb_write(input logic [4:0] idx, input logic [31:0] d);
    wb_en = 1'b1; wb_rd = idx; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
    in_valid = 1'b1; out_ready = 1'b1; in_instr = ins; in_pc = pc;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h40;
    out_ready = 1'b0; wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'h1234;
    tick();
    tick();
    rst = 1'b0; in_valid = 1'b0; wb_en = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    checks++;
    if (out_pc !== RP) begin errors++; $display("FAIL reset_pc got %h want %h", out_pc, RP); end
    checks++;
    if ({out_sel, out_a, out_b, out_rd, out_we, out_illegal} !== 75'd0) begin
      errors++;
      $display("FAIL reset_fields got sel=%h a=%h b=%h rd=%0d we=%b ill=%b want all 0",
               out_sel, out_a, out_b, out_rd, out_we, out_illegal);
    end
  endtask

  task automatic test_add();
    wb_write(5'd1, 32'd5);
    wb_write(5'd2, 32'd7);
    issue(rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33), 32'h10);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %0b want 1", out_valid); end
    checks++;
    if ({out_sel, out_a, out_b, out_rd, out_we, out_illegal} !== {4'd0, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL add_fields got sel=%h a=%0d b=%0d rd=%0d we=%b ill=%b want sel=0 a=5 b=7 rd=3 we=1 ill=0",
               out_sel, out_a, out_b, out_rd, out_we, out_illegal);
    end
  endtask

  task automatic test_alu_codes();
    wb_write(5'd1, 32'hFFFF_FFF0);
    issue(32'h4040D213, 32'h14);
    checks++;
    if ({out_sel, out_a, out_b, out_rd} !== {4'hD, 32'hFFFF_FFF0, 32'd4, 5'd4}) begin
      errors++; $display("FAIL srai got sel=%h a=%h b=%h rd=%0d want sel=d a=fffffff0 b=4 rd=4", out_sel, out_a, out_b, out_rd);
    end
    issue(rtype(7'h20, 5'd2, 5'd1, 3'd0, 5'd5, 7'h33), 32'h18);
    checks++;
    if ({out_sel, out_b, out_we} !== {4'h8, 32'd7, 1'b1}) begin
      errors++; $display("FAIL sub got sel=%h b=%h we=%b want sel=8 b=7 we=1", out_sel, out_b, out_we);
    end
    wb_write(5'd2, 32'h23);
    issue(rtype(7'h00, 5'd2, 5'd1, 3'd1, 5'd8, 7'h33), 32'h1C);
    checks++;
    if ({out_sel, out_b} !== {4'h1, 32'd3}) begin
      errors++; $display("FAIL sll_mask got sel=%h b=%h want sel=1 b=3", out_sel, out_b);
    end
    issue(rtype(7'h20, 5'd2, 5'd1, 3'd1, 5'd8, 7'h33), 32'h20);
    checks++;
    if ({out_illegal, out_we, out_sel, out_a} !== {1'b1, 1'b0, 4'd0, 32'd0}) begin
      errors++; $display("FAIL op_bad_f7 got ill=%b we=%b sel=%h a=%h want ill=1 we=0 sel=0 a=0", out_illegal, out_we, out_sel, out_a);
    end
  endtask

  task automatic test_stall();
    exp_t snap;
    logic [31:0] snap_pc;
    issue(rtype(7'h00, 5'd2, 5'd1, 3'd4, 5'd12, 7'h33), 32'h200);
    snap = {out_sel, out_a, out_b, out_rd, out_we, out_illegal};
    snap_pc = out_pc;
    in_valid = 1'b1; out_ready = 1'b0;
    in_instr = rtype(7'h00, 5'd1, 5'd1, 3'd0, 5'd13, 7'h33); in_pc = 32'h204;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cycle %0d got %b want 0", c, in_ready); end
      tick();
      checks++;
      if ({out_valid, out_sel, out_a, out_b, out_rd, out_we, out_illegal, out_pc} !== {1'b1, snap, snap_pc}) begin
        errors++; $display("FAIL stall_hold cycle %0d got rd=%0d a=%h pc=%h want rd=%0d a=%h pc=%h",
                           c, out_rd, out_a, out_pc, snap.rd, snap.a, snap_pc);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b want 1", in_ready); end
    tick();
    checks++;
    if ({out_valid, out_rd, out_pc} !== {1'b1, 5'd13, 32'h204}) begin
      errors++; $display("FAIL b2b_first got v=%b rd=%0d pc=%h want v=1 rd=13 pc=204", out_valid, out_rd, out_pc);
    end
    in_instr = rtype(7'h00, 5'd1, 5'd2, 3'd0, 5'd14, 7'h33); in_pc = 32'h208;
    tick();
    checks++;
    if ({out_valid, out_rd, out_pc} !== {1'b1, 5'd14, 32'h208}) begin
      errors++; $display("FAIL b2b_second got v=%b rd=%0d pc=%h want v=1 rd=14 pc=208", out_valid, out_rd, out_pc);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %b want 0", out_valid); end
  endtask

  task automatic test_wb_hazard();
    logic [31:0] want_a;
`ifdef WB_BYPASS_EN
    want_a = 32'd9;
`else
    want_a = 32'hFFFF_FFF0;
`endif
    wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'd9;
    issue(rtype(7'h00, 5'd0, 5'd1, 3'd0, 5'd6, 7'h33), 32'h300);
    wb_en = 1'b0;
    checks++;
    if ({out_a, out_b} !== {want_a, 32'd0}) begin
      errors++; $display("FAIL wb_same_cycle got a=%h b=%h want a=%h b=0", out_a, out_b, want_a);
    end
    issue(rtype(7'h00, 5'd0, 5'd1, 3'd0, 5'd10, 7'h33), 32'h304);
    checks++;
    if (out_a !== 32'd9) begin errors++; $display("FAIL wb_committed got a=%h want 9", out_a); end
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'h55;
    issue(rtype(7'h00, 5'd0, 5'd0, 3'd0, 5'd9, 7'h33), 32'h308);
    wb_en = 1'b0;
    issue(rtype(7'h00, 5'd0, 5'd0, 3'd0, 5'd9, 7'h33), 32'h30C);
    checks++;
    if ({out_a, out_b} !== 64'd0) begin errors++; $display("FAIL x0_write got a=%h b=%h want 0 0", out_a, out_b); end
  endtask

  task automatic test_upper_illegal();
    issue(32'h123453B7, 32'h400);
    checks++;
    if ({out_sel, out_a, out_b, out_rd, out_we} !== {4'd0, 32'd0, 32'h1234_5000, 5'd7, 1'b1}) begin
      errors++; $display("FAIL lui got sel=%h a=%h b=%h rd=%0d we=%b want sel=0 a=0 b=12345000 rd=7 we=1",
                         out_sel, out_a, out_b, out_rd, out_we);
    end
    issue(32'h00001597, 32'h100);
    checks++;
    if ({out_sel, out_a, out_b, out_pc} !== {4'd0, 32'h100, 32'h1000, 32'h100}) begin
      errors++; $display("FAIL auipc got sel=%h a=%h b=%h pc=%h want sel=0 a=100 b=1000 pc=100", out_sel, out_a, out_b, out_pc);
    end
    issue(32'h0000006F, 32'h104);
    checks++;
    if ({out_valid, out_illegal, out_we, out_sel, out_a, out_b, out_rd} !== {1'b1, 1'b1, 1'b0, 4'd0, 64'd0, 5'd0}) begin
      errors++; $display("FAIL jal_illegal got v=%b ill=%b we=%b sel=%h a=%h b=%h want v=1 ill=1 we=0 sel=0 a=0 b=0",
                         out_valid, out_illegal, out_we, out_sel, out_a, out_b);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom();
    case ($urandom_range(0, 6))
      0, 1:    w[6:0] = 7'h33;
      2, 3:    w[6:0] = 7'h13;
      4:       w[6:0] = 7'h37;
      5:       w[6:0] = 7'h17;
      default: ;
    endcase
    if (w[6:0] == 7'h33 || w[6:0] == 7'h13) begin
      case ($urandom_range(0, 3))
        0:       w[31:25] = 7'h00;
        1:       w[31:25] = 7'h20;
        default: ;
      endcase
    end
    return w;
  endfunction

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_instr  = rand_instr();
      in_pc     = $urandom() & 32'hFFFF_FFFC;
      wb_en     = ($urandom_range(0, 2) == 0);
      wb_rd     = 5'($urandom_range(0, 7));
      wb_data   = $urandom();
      #1;
      checks++;
      if (in_ready !== (!m_valid || out_ready)) begin
        errors++; $display("FAIL rand_in_ready step %0d got %b want %b", n, in_ready, !m_valid || out_ready);
      end
      tick();
      checks++;
      if (out_valid !== m_valid) begin
        errors++; $display("FAIL rand_valid step %0d got %b want %b", n, out_valid, m_valid);
      end else if (m_valid && {out_sel, out_a, out_b, out_rd, out_we, out_illegal, out_pc} !== {m_out, m_pc}) begin
        errors++;
        $display("FAIL rand_fields step %0d got sel=%h a=%h b=%h rd=%0d we=%b ill=%b pc=%h want sel=%h a=%h b=%h rd=%0d we=%b ill=%b pc=%h",
                 n, out_sel, out_a, out_b, out_rd, out_we, out_illegal, out_pc,
                 m_out.sel, m_out.a, m_out.b, m_out.rd, m_out.we, m_out.ill, m_pc);
      end
    end
    in_valid = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 1; i < 32; i++) wb_write(5'(i), 32'h100 + 32'(i));
    issue(rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33), 32'h500);
    out_ready = 1'b0; in_valid = 1'b1; in_instr = rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd4, 7'h33);
    wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'd77; rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; wb_en = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, out_pc, out_we} !== {1'b0, 1'b1, RP, 1'b0}) begin
      errors++; $display("FAIL midreset got v=%b rdy=%b pc=%h we=%b want v=0 rdy=1 pc=%h we=0", out_valid, in_ready, out_pc, out_we, RP);
    end
    for (int i = 1; i < 32; i++) begin
      issue(rtype(7'h00, 5'(i), 5'(i), 3'd0, 5'd1, 7'h33), 32'h600);
      checks++;
      if ({out_a, out_b} !== 64'd0) begin
        errors++; $display("FAIL cleared_x%0d got a=%h b=%h want 0 0", i, out_a, out_b);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b1;
    m_valid = 1'b0; m_out = '0; m_pc = RP;
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    test_reset();
    test_add();
    test_alu_codes();
    test_stall();
    test_wb_hazard();
    test_upper_illegal();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
